// File: rtl/watch_timekeeper.sv
// Watch timekeeper: BCD time of day with set mode, a mm:ss stopwatch with a
// split register, a registered two-digit-pair display mux and an alarm.
module watch_timekeeper #(
   parameter int CLKS_PER_SEC = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_sec_normal,
   input  logic       en_sec_sw,
   input  logic       sw_clear,
   input  logic       save_split,
   input  logic [7:0] set_hh,
   input  logic [7:0] set_mm,
   input  logic [7:0] alarm_hh,
   input  logic [7:0] alarm_mm,
   input  logic       alarm_en,
   input  logic       alarm_ack,
   input  logic       sel_hr,
   input  logic       sel_min,
   input  logic       sel_hr_sw,
   input  logic       sel_min_sw,
   output logic [7:0] time_hh,
   output logic [7:0] time_mm,
   output logic [7:0] time_ss,
   output logic [7:0] disp_hh,
   output logic [7:0] disp_mm,
   output logic       alarm_ring
);

   localparam int PW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(CLKS_PER_SEC - 1);

   // Two-digit BCD increment that wraps to 00 after 'last'.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
      logic [7:0] r;
      if (v == last)
         r = 8'h00;
      else if (v[3:0] == 4'd9)
         r = {v[7:4] + 4'd1, 4'd0};
      else
         r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   function automatic logic legal_mm(input logic [7:0] v);
      return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
   endfunction

   function automatic logic legal_hh(input logic [7:0] v);
      return (v[3:0] <= 4'd9) &&
             ((v[7:4] <= 4'd1) || ((v[7:4] == 4'd2) && (v[3:0] <= 4'd3)));
   endfunction

   logic [PW-1:0] presc_reg;
   logic          sec_tick;
   logic [7:0]    hh_next, mm_next, ss_next;
   logic          alarm_hit;
   logic [5:0]    ring_cnt_reg;
   logic [7:0]    sw_mm_reg, sw_ss_reg, split_mm_reg, split_ss_reg;
   logic          save_prev_reg;

   assign sec_tick = (presc_reg == PRESC_LAST);

   // Prescaler: free-running divider, parked at zero while the time is being set.
   always_ff @(posedge clk) begin
      if (rst || !en_sec_normal)
         presc_reg <= '0;
      else if (sec_tick)
         presc_reg <= '0;
      else
         presc_reg <= presc_reg + PW'(1);
   end

   // Next time of day: load legal set fields in set mode, else advance on tick.
   always_comb begin
      hh_next = time_hh;
      mm_next = time_mm;
      ss_next = time_ss;
      if (!en_sec_normal) begin
         if (legal_hh(set_hh)) hh_next = set_hh;
         if (legal_mm(set_mm)) mm_next = set_mm;
         ss_next = 8'h00;
      end else if (sec_tick) begin
         ss_next = bcd_inc(time_ss, 8'h59);
         if (time_ss == 8'h59) begin
            mm_next = bcd_inc(time_mm, 8'h59);
            if (time_mm == 8'h59)
               hh_next = bcd_inc(time_hh, 8'h23);
         end
      end
   end

   // Only a counting tick can trigger, so a set-mode load never rings.
   assign alarm_hit = en_sec_normal && sec_tick && alarm_en &&
                      (hh_next == alarm_hh) && (mm_next == alarm_mm) && (ss_next == 8'h00);

   // Time-of-day registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         time_hh <= 8'h00;
         time_mm <= 8'h00;
         time_ss <= 8'h00;
      end else begin
         time_hh <= hh_next;
         time_mm <= mm_next;
         time_ss <= ss_next;
      end
   end

   // Alarm ring: ack/disable beat a trigger; self-clears on the 60th tick after it.
   always_ff @(posedge clk) begin
      if (rst) begin
         alarm_ring   <= 1'b0;
         ring_cnt_reg <= '0;
      end else if (alarm_ack || !alarm_en) begin
         alarm_ring   <= 1'b0;
         ring_cnt_reg <= '0;
      end else if (alarm_hit) begin
         alarm_ring   <= 1'b1;
         ring_cnt_reg <= '0;
      end else if (alarm_ring && sec_tick) begin
         if (ring_cnt_reg == 6'd59) begin
            alarm_ring   <= 1'b0;
            ring_cnt_reg <= '0;
         end else begin
            ring_cnt_reg <= ring_cnt_reg + 6'd1;
         end
      end
   end

   // Edge detector for the split capture.
   always_ff @(posedge clk) begin
      if (rst)
         save_prev_reg <= 1'b0;
      else
         save_prev_reg <= save_split;
   end

   // Stopwatch and split: clear wins; split grabs the pre-increment value.
   always_ff @(posedge clk) begin
      if (rst || sw_clear) begin
         sw_mm_reg    <= 8'h00;
         sw_ss_reg    <= 8'h00;
         split_mm_reg <= 8'h00;
         split_ss_reg <= 8'h00;
      end else begin
         if (sec_tick && en_sec_sw) begin
            sw_ss_reg <= bcd_inc(sw_ss_reg, 8'h59);
            if (sw_ss_reg == 8'h59)
               sw_mm_reg <= bcd_inc(sw_mm_reg, 8'h59);
         end
         if (save_split && !save_prev_reg) begin
            split_mm_reg <= sw_mm_reg;
            split_ss_reg <= sw_ss_reg;
         end
      end
   end

   // Display channel 0 drives disp_hh, channel 1 drives disp_mm.
   logic [7:0] sw_val    [2];
   logic [7:0] split_val [2];
   logic [7:0] tod_val   [2];
   logic [7:0] set_val   [2];
   logic       sel_sw    [2];
   logic       sel_tod   [2];

   assign sw_val[0]    = sw_mm_reg;
   assign sw_val[1]    = sw_ss_reg;
   assign split_val[0] = split_mm_reg;
   assign split_val[1] = split_ss_reg;
   assign tod_val[0]   = time_hh;
   assign tod_val[1]   = time_mm;
   assign set_val[0]   = set_hh;
   assign set_val[1]   = set_mm;
   assign sel_sw[0]    = sel_hr_sw;
   assign sel_sw[1]    = sel_min_sw;
   assign sel_tod[0]   = sel_hr;
   assign sel_tod[1]   = sel_min;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_disp
         logic [7:0] disp_reg;
         // Registered display mux: stopwatch/split, then time of day, then set value.
         always_ff @(posedge clk) begin
            if (rst)
               disp_reg <= 8'h00;
            else if (sel_sw[gi])
               disp_reg <= save_split ? split_val[gi] : sw_val[gi];
            else if (sel_tod[gi])
               disp_reg <= tod_val[gi];
            else
               disp_reg <= set_val[gi];
         end
      end
   endgenerate

   assign disp_hh = g_disp[0].disp_reg;
   assign disp_mm = g_disp[1].disp_reg;

endmodule

// File: tb/tb_watch_timekeeper.sv
// Self-checking bench for watch_timekeeper: directed scenarios plus random
// stimulus, all checked against a seconds-based reference model.
module tb_watch_timekeeper;

   logic       clk = 1'b0;
   logic       rst, en_sec_normal, en_sec_sw, sw_clear, save_split;
   logic [7:0] set_hh, set_mm, alarm_hh, alarm_mm;
   logic       alarm_en, alarm_ack, sel_hr, sel_min, sel_hr_sw, sel_min_sw;
   logic [7:0] time_hh, time_mm, time_ss, disp_hh, disp_mm;
   logic       alarm_ring;

   int total = 0;
   int bad   = 0;

   // Reference model state: plain integer seconds.
   int         m_tod, m_sw, m_split, m_ring_cnt;
   bit         m_ring, m_prev;
   logic [7:0] m_disp_hh, m_disp_mm;

   watch_timekeeper #(.CLKS_PER_SEC(1)) dut (
      .clk(clk), .rst(rst), .en_sec_normal(en_sec_normal), .en_sec_sw(en_sec_sw),
      .sw_clear(sw_clear), .save_split(save_split), .set_hh(set_hh), .set_mm(set_mm),
      .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_en(alarm_en), .alarm_ack(alarm_ack),
      .sel_hr(sel_hr), .sel_min(sel_min), .sel_hr_sw(sel_hr_sw), .sel_min_sw(sel_min_sw),
      .time_hh(time_hh), .time_mm(time_mm), .time_ss(time_ss),
      .disp_hh(disp_hh), .disp_mm(disp_mm), .alarm_ring(alarm_ring)
   );

   always #5 clk = ~clk;

   function automatic int bcd2int(input logic [7:0] v);
      return int'(v[7:4]) * 10 + int'(v[3:0]);
   endfunction

   function automatic logic [7:0] int2bcd(input int n);
      return 8'(((n / 10) * 16) + (n % 10));
   endfunction

   function automatic bit ok_hh(input logic [7:0] v);
      return (v[3:0] < 4'd10) && (bcd2int(v) < 24);
   endfunction

   function automatic bit ok_mm(input logic [7:0] v);
      return (v[3:0] < 4'd10) && (v[7:4] < 4'd6);
   endfunction

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   // One clock edge of the reference model (one second per clock).
   task automatic model_edge();
      int hh, mm, pick;
      bit hit;
      if (rst) begin
         m_tod = 0; m_sw = 0; m_split = 0; m_ring = 0; m_ring_cnt = 0; m_prev = 0;
         m_disp_hh = 8'h00; m_disp_mm = 8'h00;
         return;
      end
      pick = save_split ? m_split : m_sw;
      m_disp_hh = sel_hr_sw ? int2bcd(pick / 60) : (sel_hr  ? int2bcd(m_tod / 3600)      : set_hh);
      m_disp_mm = sel_min_sw ? int2bcd(pick % 60) : (sel_min ? int2bcd((m_tod / 60) % 60) : set_mm);
      if (!en_sec_normal) begin
         hh = ok_hh(set_hh) ? bcd2int(set_hh) : m_tod / 3600;
         mm = ok_mm(set_mm) ? bcd2int(set_mm) : (m_tod / 60) % 60;
         m_tod = hh * 3600 + mm * 60;
      end else begin
         m_tod = (m_tod + 1) % 86400;
      end
      hit = en_sec_normal && alarm_en &&
            (m_tod == bcd2int(alarm_hh) * 3600 + bcd2int(alarm_mm) * 60);
      if (alarm_ack || !alarm_en) begin
         m_ring = 0;
      end else if (hit) begin
         m_ring = 1; m_ring_cnt = 0;
      end else if (m_ring) begin
         m_ring_cnt++;
         if (m_ring_cnt == 60) m_ring = 0;
      end
      if (sw_clear) begin
         m_sw = 0; m_split = 0;
      end else begin
         if (save_split && !m_prev) m_split = m_sw;
         if (en_sec_sw) m_sw = (m_sw + 1) % 3600;
      end
      m_prev = save_split;
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_hh"},   time_hh,    int2bcd(m_tod / 3600));
      chk({tag, "_mm"},   time_mm,    int2bcd((m_tod / 60) % 60));
      chk({tag, "_ss"},   time_ss,    int2bcd(m_tod % 60));
      chk({tag, "_dhh"},  disp_hh,    m_disp_hh);
      chk({tag, "_dmm"},  disp_mm,    m_disp_mm);
      chk({tag, "_ring"}, {7'd0, alarm_ring}, {7'd0, m_ring});
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(tag);
   endtask

   initial begin
      rst = 1; en_sec_normal = 0; en_sec_sw = 0; sw_clear = 0; save_split = 0;
      set_hh = 8'h00; set_mm = 8'h00; alarm_hh = 8'h00; alarm_mm = 8'h00;
      alarm_en = 0; alarm_ack = 0; sel_hr = 0; sel_min = 0; sel_hr_sw = 0; sel_min_sw = 0;
      m_tod = 0; m_sw = 0; m_split = 0; m_ring = 0; m_ring_cnt = 0; m_prev = 0;
      m_disp_hh = 8'h00; m_disp_mm = 8'h00;

      // Reset state
      step("rst");
      chk("rst_time_hh", time_hh, 8'h00);
      chk("rst_disp_mm", disp_mm, 8'h00);
      rst = 0;
      $display("reset: total=%0d bad=%0d", total, bad);

      // Day rollover
      set_hh = 8'h23; set_mm = 8'h59;
      step("roll_load");
      en_sec_normal = 1;
      repeat (59) step("roll");
      chk("roll_ss59", time_ss, 8'h59);
      step("roll");
      chk("roll_hh0", time_hh, 8'h00);
      chk("roll_mm0", time_mm, 8'h00);
      chk("roll_ss0", time_ss, 8'h00);
      step("roll");
      chk("roll_ss1", time_ss, 8'h01);
      $display("rollover: total=%0d bad=%0d", total, bad);

      // Set mode, including illegal fields
      en_sec_normal = 0; set_hh = 8'h12; set_mm = 8'h30;
      step("set");
      chk("set_hh", time_hh, 8'h12);
      chk("set_mm", time_mm, 8'h30);
      chk("set_ss", time_ss, 8'h00);
      set_mm = 8'h7A; set_hh = 8'h24;
      step("set_bad");
      chk("set_bad_mm", time_mm, 8'h30);
      chk("set_bad_hh", time_hh, 8'h12);
      sel_hr = 0; sel_min = 0;
      step("set_disp");
      chk("set_disp_mm", disp_mm, 8'h7A);
      $display("set mode: total=%0d bad=%0d", total, bad);

      // Stopwatch full range and wrap
      en_sec_normal = 1; sel_hr_sw = 1; sel_min_sw = 1; sw_clear = 1;
      step("sw_clr");
      sw_clear = 0; en_sec_sw = 1;
      repeat (3540) step("sw");
      en_sec_sw = 0;
      step("sw_hold");
      chk("sw_5900_hh", disp_hh, 8'h59);
      chk("sw_5900_mm", disp_mm, 8'h00);
      en_sec_sw = 1;
      repeat (59) step("sw");
      en_sec_sw = 0;
      step("sw_hold");
      chk("sw_5959_mm", disp_mm, 8'h59);
      en_sec_sw = 1;
      step("sw_wrap");
      en_sec_sw = 0;
      step("sw_hold");
      chk("sw_wrap_hh", disp_hh, 8'h00);
      chk("sw_wrap_mm", disp_mm, 8'h00);
      $display("stopwatch: total=%0d bad=%0d", total, bad);

      // Split capture
      sw_clear = 1;
      step("sp_clr");
      sw_clear = 0; en_sec_sw = 1;
      repeat (15) step("sp");
      save_split = 1;
      repeat (10) step("sp");
      en_sec_sw = 0;
      step("sp_show");
      chk("split_mm", disp_mm, 8'h15);
      chk("split_hh", disp_hh, 8'h00);
      save_split = 0;
      step("sp_track");
      chk("split_track", disp_mm, 8'h25);
      $display("split: total=%0d bad=%0d", total, bad);

      // Alarm with ack, then timeout
      alarm_hh = 8'h06; alarm_mm = 8'h45; alarm_en = 1;
      en_sec_normal = 0; set_hh = 8'h06; set_mm = 8'h45;
      step("al_setmatch");
      chk("al_no_set_trig", {7'd0, alarm_ring}, 8'h00);
      set_mm = 8'h44;
      step("al_load");
      en_sec_normal = 1;
      repeat (59) step("al");
      chk("al_pre", {7'd0, alarm_ring}, 8'h00);
      step("al_hit");
      chk("al_ring", {7'd0, alarm_ring}, 8'h01);
      alarm_ack = 1;
      step("al_ack");
      chk("al_acked", {7'd0, alarm_ring}, 8'h00);
      alarm_ack = 0; en_sec_normal = 0;
      step("al_load2");
      en_sec_normal = 1;
      repeat (60) step("al2");
      chk("al2_ring", {7'd0, alarm_ring}, 8'h01);
      repeat (59) step("al2_hold");
      chk("al2_still", {7'd0, alarm_ring}, 8'h01);
      step("al2_to");
      chk("al2_timeout", {7'd0, alarm_ring}, 8'h00);
      $display("alarm: total=%0d bad=%0d", total, bad);

      // Reset mid-operation
      en_sec_normal = 0; set_mm = 8'h44;
      step("mid_load");
      en_sec_normal = 1; en_sec_sw = 1; sel_hr = 1; sel_min = 1;
      repeat (62) step("mid_run");
      chk("mid_ring_on", {7'd0, alarm_ring}, 8'h01);
      rst = 1;
      step("mid_rst");
      chk("mid_hh", time_hh, 8'h00);
      chk("mid_ss", time_ss, 8'h00);
      chk("mid_disp", disp_hh | disp_mm, 8'h00);
      chk("mid_ring", {7'd0, alarm_ring}, 8'h00);
      rst = 0;
      $display("mid reset: total=%0d bad=%0d", total, bad);

      // Random stimulus against the model
      for (int i = 0; i < 6000; i++) begin
         rst           = ($urandom_range(0, 299) == 0);
         en_sec_normal = ($urandom_range(0, 9) != 0);
         en_sec_sw     = ($urandom_range(0, 3) != 0);
         sw_clear      = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 7) == 0) save_split = ~save_split;
         set_hh        = ($urandom_range(0, 3) == 0) ? 8'($urandom) : int2bcd($urandom_range(0, 23));
         set_mm        = ($urandom_range(0, 3) == 0) ? 8'($urandom) : int2bcd($urandom_range(0, 59));
         alarm_en      = ($urandom_range(0, 199) != 0);
         alarm_ack     = ($urandom_range(0, 99) == 0);
         sel_hr        = $urandom_range(0, 1) == 1;
         sel_min       = $urandom_range(0, 1) == 1;
         sel_hr_sw     = $urandom_range(0, 1) == 1;
         sel_min_sw    = $urandom_range(0, 1) == 1;
         if (i % 150 == 0) begin
            int t;
            t = (m_tod / 60 + 1 + int'($urandom_range(0, 1))) % 1440;
            alarm_hh = int2bcd(t / 60);
            alarm_mm = int2bcd(t % 60);
         end
         step("rnd");
      end
      $display("random: total=%0d bad=%0d", total, bad);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
